// File: rtl/sync_fifo_pkg.sv
// Shared sizing helpers for the parametrised synchronous FIFO.
// Pointer and occupancy widths are derived from DEPTH in one place.
package sync_fifo_pkg;

  // Pointer width: enough bits to address DEPTH entries; wraps naturally.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width: one extra bit so the value DEPTH fits.
  function automatic int cnt_w(input int depth);
    return ptr_w(depth) + 1;
  endfunction

  localparam int DEFAULT_DEPTH = 16;
  localparam int DEFAULT_CNT_W = cnt_w(DEFAULT_DEPTH);

  typedef logic [DEFAULT_CNT_W-1:0] count_t;

endpackage

// File: rtl/sync_fifo_param_if.sv
// Producer/consumer bus of the synchronous FIFO; the FIFO takes the slave side.
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) ();

  localparam int CNT_W = cnt_w(DEPTH);

  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              clr_err;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, wr_data, rd_en, clr_err,
    input  rd_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en, clr_err,
    output rd_data, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ram.sv
// Simple dual-port register array: synchronous write, asynchronous read.
module sync_fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ptr_w(DEPTH)-1:0]  waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [ptr_w(DEPTH)-1:0]  raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Contents are deliberately not reset; pointers define what is valid.
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, almost flags,
// sticky overflow/underflow and selectable first-word-fall-through read.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sync_fifo_param_if.slave     bus
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_almost_full;
  logic              r_almost_empty;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_rd_ok;
  logic              w_wr_ok;
  logic              w_ram_we;
  logic [CNT_W-1:0]  w_count_next;
  logic [DATA_W-1:0] w_ram_rdata;

  // A write into a full FIFO is allowed only when a pop frees a slot the
  // same cycle; an empty FIFO never bypasses write data to the reader.
  assign w_rd_ok  = bus.rd_en & ~r_empty;
  assign w_wr_ok  = bus.wr_en & (~r_full | w_rd_ok);
  assign w_ram_we = w_wr_ok & rst_n;

  always_comb begin
    w_count_next = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= (AF_THRESH == 0);
      r_almost_empty <= 1'b1;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count        <= w_count_next;
      r_full         <= (w_count_next == DEPTH_C);
      r_empty        <= (w_count_next == '0);
      r_almost_full  <= (w_count_next >= AF_C);
      r_almost_empty <= (w_count_next <= AE_C);
    end
  end

  // Sticky errors: a new rejection in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (bus.wr_en & ~w_wr_ok) begin
        r_overflow <= 1'b1;
      end else if (bus.clr_err) begin
        r_overflow <= 1'b0;
      end
      if (bus.rd_en & ~w_rd_ok) begin
        r_underflow <= 1'b1;
      end else if (bus.clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  sync_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we     (w_ram_we),
    .waddr  (r_wr_ptr),
    .wdata  (bus.wr_data),
    .raddr  (r_rd_ptr),
    .rdata  (w_ram_rdata)
  );

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.rd_data = r_empty ? '0 : w_ram_rdata;
    end else begin : g_std
      logic [DATA_W-1:0] r_rd_data;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_data <= '0;
        end else if (w_rd_ok) begin
          r_rd_data <= w_ram_rdata;
        end
      end

      assign bus.rd_data = r_rd_data;
    end
  endgenerate

  assign bus.count        = r_count;
  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_almost_full;
  assign bus.almost_empty = r_almost_empty;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench: a standard-read FIFO and an FWFT FIFO, both DEPTH=4.
module tb_sync_fifo_param;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  sync_fifo_param_if #(.DATA_W(8), .DEPTH(4)) bus_s ();
  sync_fifo_param_if #(.DATA_W(8), .DEPTH(4)) bus_f ();

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(0)
  ) u_dut_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1), .FWFT(1)
  ) u_dut_fwft (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus_s.wr_en = 1'b0; bus_s.rd_en = 1'b0; bus_s.wr_data = 8'h00; bus_s.clr_err = 1'b0;
    bus_f.wr_en = 1'b0; bus_f.rd_en = 1'b0; bus_f.wr_data = 8'h00; bus_f.clr_err = 1'b0;
    repeat (2) tick();

    chk("rst_empty", 32'(bus_s.empty), 32'd1);
    chk("rst_full", 32'(bus_s.full), 32'd0);
    chk("rst_ae", 32'(bus_s.almost_empty), 32'd1);
    chk("rst_af", 32'(bus_s.almost_full), 32'd0);
    chk("rst_count", 32'(bus_s.count), 32'd0);
    chk("rst_rd_data", 32'(bus_s.rd_data), 32'h00);
    chk("rst_ovf", 32'(bus_s.overflow), 32'd0);
    chk("rst_udf", 32'(bus_s.underflow), 32'd0);
    $display("reset: empty=%0d count=%0d", bus_s.empty, bus_s.count);
    rst_n = 1'b1;
    tick();

    // Fill 0x11..0x44
    bus_s.wr_en = 1'b1; bus_s.wr_data = 8'h11; tick();
    chk("fill1_count", 32'(bus_s.count), 32'd1);
    chk("fill1_ae", 32'(bus_s.almost_empty), 32'd1);
    chk("fill1_empty", 32'(bus_s.empty), 32'd0);
    $display("write 11: count=%0d", bus_s.count);
    bus_s.wr_data = 8'h22; tick();
    chk("fill2_count", 32'(bus_s.count), 32'd2);
    chk("fill2_ae", 32'(bus_s.almost_empty), 32'd0);
    chk("fill2_af", 32'(bus_s.almost_full), 32'd0);
    $display("write 22: count=%0d", bus_s.count);
    bus_s.wr_data = 8'h33; tick();
    chk("fill3_count", 32'(bus_s.count), 32'd3);
    chk("fill3_af", 32'(bus_s.almost_full), 32'd1);
    chk("fill3_full", 32'(bus_s.full), 32'd0);
    $display("write 33: count=%0d af=%0d", bus_s.count, bus_s.almost_full);
    bus_s.wr_data = 8'h44; tick();
    chk("fill4_count", 32'(bus_s.count), 32'd4);
    chk("fill4_full", 32'(bus_s.full), 32'd1);
    $display("write 44: count=%0d full=%0d", bus_s.count, bus_s.full);

    // Overflow: rejected write of 0x55
    bus_s.wr_data = 8'h55; tick();
    chk("ovf_flag", 32'(bus_s.overflow), 32'd1);
    chk("ovf_count", 32'(bus_s.count), 32'd4);
    $display("write 55 when full: overflow=%0d count=%0d", bus_s.overflow, bus_s.count);
    bus_s.wr_en = 1'b0; bus_s.clr_err = 1'b1; tick();
    bus_s.clr_err = 1'b0;
    chk("clr_ovf", 32'(bus_s.overflow), 32'd0);
    $display("clr_err: overflow=%0d", bus_s.overflow);

    // Simultaneous write+read on full
    bus_s.wr_en = 1'b1; bus_s.rd_en = 1'b1; bus_s.wr_data = 8'h66; tick();
    chk("simfull_count", 32'(bus_s.count), 32'd4);
    chk("simfull_rd", 32'(bus_s.rd_data), 32'h11);
    chk("simfull_ovf", 32'(bus_s.overflow), 32'd0);
    $display("wr66+rd on full: rd_data=%0h count=%0d", bus_s.rd_data, bus_s.count);

    // Drain: 22,33,44,66 (0x55 never appears)
    bus_s.wr_en = 1'b0;
    tick(); chk("rd_22", 32'(bus_s.rd_data), 32'h22); chk("rd_22_cnt", 32'(bus_s.count), 32'd3);
    $display("read: rd_data=%0h count=%0d", bus_s.rd_data, bus_s.count);
    tick(); chk("rd_33", 32'(bus_s.rd_data), 32'h33); chk("rd_33_cnt", 32'(bus_s.count), 32'd2);
    $display("read: rd_data=%0h count=%0d", bus_s.rd_data, bus_s.count);
    tick(); chk("rd_44", 32'(bus_s.rd_data), 32'h44); chk("rd_44_cnt", 32'(bus_s.count), 32'd1);
    $display("read: rd_data=%0h count=%0d", bus_s.rd_data, bus_s.count);
    tick(); chk("rd_66", 32'(bus_s.rd_data), 32'h66); chk("rd_66_empty", 32'(bus_s.empty), 32'd1);
    $display("read: rd_data=%0h empty=%0d", bus_s.rd_data, bus_s.empty);
    bus_s.rd_en = 1'b0; tick();
    chk("hold_rd", 32'(bus_s.rd_data), 32'h66);
    chk("hold_udf", 32'(bus_s.underflow), 32'd0);
    $display("idle: rd_data=%0h", bus_s.rd_data);

    // Simultaneous on empty: read rejected, write accepted
    bus_s.wr_en = 1'b1; bus_s.rd_en = 1'b1; bus_s.wr_data = 8'h77; tick();
    chk("simempty_udf", 32'(bus_s.underflow), 32'd1);
    chk("simempty_count", 32'(bus_s.count), 32'd1);
    chk("simempty_rd", 32'(bus_s.rd_data), 32'h66);
    $display("wr77+rd on empty: underflow=%0d count=%0d", bus_s.underflow, bus_s.count);
    bus_s.wr_en = 1'b0; tick();
    bus_s.rd_en = 1'b0;
    chk("rd_77", 32'(bus_s.rd_data), 32'h77);
    chk("rd_77_cnt", 32'(bus_s.count), 32'd0);
    chk("udf_sticky", 32'(bus_s.underflow), 32'd1);
    $display("read: rd_data=%0h underflow=%0d", bus_s.rd_data, bus_s.underflow);
    bus_s.clr_err = 1'b1; tick();
    bus_s.clr_err = 1'b0;
    chk("clr_udf", 32'(bus_s.underflow), 32'd0);
    $display("clr_err: underflow=%0d", bus_s.underflow);

    // Wrap-around: 10 interleaved write/read pairs
    for (int i = 0; i < 10; i++) begin
      bus_s.wr_en = 1'b1; bus_s.wr_data = 8'(i); tick();
      bus_s.wr_en = 1'b0;
      chk("wrap_wcnt", 32'(bus_s.count), 32'd1);
      bus_s.rd_en = 1'b1; tick();
      bus_s.rd_en = 1'b0;
      chk("wrap_data", 32'(bus_s.rd_data), 32'(i));
      chk("wrap_rcnt", 32'(bus_s.count), 32'd0);
      $display("wrap pair %0d: rd_data=%0h", i, bus_s.rd_data);
    end
    chk("wrap_ovf", 32'(bus_s.overflow), 32'd0);
    chk("wrap_udf", 32'(bus_s.underflow), 32'd0);

    // FWFT instance
    chk("fwft_rst_rd", 32'(bus_f.rd_data), 32'h00);
    bus_f.wr_en = 1'b1; bus_f.wr_data = 8'hA5; tick();
    bus_f.wr_en = 1'b0;
    chk("fwft_a5", 32'(bus_f.rd_data), 32'hA5);
    chk("fwft_a5_cnt", 32'(bus_f.count), 32'd1);
    $display("fwft write a5: rd_data=%0h", bus_f.rd_data);
    tick();
    chk("fwft_a5_hold", 32'(bus_f.rd_data), 32'hA5);
    bus_f.rd_en = 1'b1; tick();
    bus_f.rd_en = 1'b0;
    chk("fwft_pop_empty", 32'(bus_f.empty), 32'd1);
    chk("fwft_pop_rd", 32'(bus_f.rd_data), 32'h00);
    $display("fwft pop: empty=%0d rd_data=%0h", bus_f.empty, bus_f.rd_data);
    bus_f.wr_en = 1'b1; bus_f.wr_data = 8'hB1; tick();
    bus_f.wr_data = 8'hB2; tick();
    bus_f.wr_en = 1'b0;
    chk("fwft_head_b1", 32'(bus_f.rd_data), 32'hB1);
    chk("fwft_cnt2", 32'(bus_f.count), 32'd2);
    bus_f.rd_en = 1'b1; tick();
    chk("fwft_head_b2", 32'(bus_f.rd_data), 32'hB2);
    tick();
    bus_f.rd_en = 1'b0;
    chk("fwft_drain_rd", 32'(bus_f.rd_data), 32'h00);
    chk("fwft_udf", 32'(bus_f.underflow), 32'd0);
    $display("fwft drain: rd_data=%0h empty=%0d", bus_f.rd_data, bus_f.empty);

    // Asynchronous reset with count=3
    bus_s.wr_en = 1'b1;
    bus_s.wr_data = 8'hC1; tick();
    bus_s.wr_data = 8'hC2; tick();
    bus_s.wr_data = 8'hC3; tick();
    bus_s.wr_en = 1'b0;
    chk("pre_arst_cnt", 32'(bus_s.count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(bus_s.count), 32'd0);
    chk("arst_empty", 32'(bus_s.empty), 32'd1);
    chk("arst_af", 32'(bus_s.almost_full), 32'd0);
    chk("arst_ae", 32'(bus_s.almost_empty), 32'd1);
    chk("arst_rd", 32'(bus_s.rd_data), 32'h00);
    $display("async reset: count=%0d empty=%0d", bus_s.count, bus_s.empty);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_arst_cnt", 32'(bus_s.count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
